apb_reg_slave: RTL and testbench

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

---
 rtl/apb_slv_pkg.sv | 37 +++
 rtl/apb_slv_regfile.sv | 56 +++++
 rtl/apb_reg_slave.sv | 102 ++++++++++
 tb/tb_apb_reg_slave.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB register slave: FSM encoding,
// register map, ID value and response codes.
package apb_slv_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned RW_REGS = 7;

    localparam logic [7:0]  OFS_CTRL = 8'h00;
    localparam logic [7:0]  OFS_R1   = 8'h04;
    localparam logic [7:0]  OFS_R2   = 8'h08;
    localparam logic [7:0]  OFS_R3   = 8'h0C;
    localparam logic [7:0]  OFS_R4   = 8'h10;
    localparam logic [7:0]  OFS_R5   = 8'h14;
    localparam logic [7:0]  OFS_R6   = 8'h18;
    localparam logic [7:0]  OFS_ID   = 8'h1C;

    localparam logic [31:0] ID_VALUE = 32'hA2B0_0001;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        READY = 2'b10
    } state_e;

    // Request captured in the setup phase and held for the whole transfer
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_slv_regfile.sv
// Register array with address decode and error check; seven R/W registers
// plus a read-only ID word at the top offset.
module apb_slv_regfile
    import apb_slv_pkg::*;
#(
    parameter logic [7:0] BASE = 8'h10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              write,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_c,
    output logic              err_c,
    output logic [DATA_W-1:0] ctrl
);

    logic [DATA_W-1:0] regs [RW_REGS];
    logic [2:0]        idx;

    // Decode, error check and read mux; a failing access always reads as zero
    always_comb begin
        idx     = addr[4:2];
        err_c   = (addr[15:8] != BASE) || (addr[7:5] != 3'b000) ||
                  (addr[1:0] != 2'b00) || (write && (addr[7:0] == OFS_ID));
        rdata_c = '0;
        if (!err_c) begin
            if (idx == OFS_ID[4:2]) begin
                rdata_c = ID_VALUE;
            end
            for (int unsigned i = 0; i < RW_REGS; i++) begin
                if (idx == 3'(i)) begin
                    rdata_c = regs[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RW_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && !err_c) begin
            for (int unsigned i = 0; i < RW_REGS; i++) begin
                if (idx == 3'(i)) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    assign ctrl = regs[OFS_CTRL[4:2]];

endmodule

// File: rtl/apb_reg_slave.sv
// APB register slave: transfer FSM with programmable wait states in front of
// the register file; every bus output comes straight from a flop.
module apb_reg_slave
    import apb_slv_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 2,
    parameter logic [7:0]  BASE     = 8'h10
) (
    input  logic        PCLK,
    input  logic        PRST_n,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [15:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] CTRL_O
);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    apb_req_t          req;

    logic [ADDR_W-1:0] dec_addr_c;
    logic              dec_write_c;
    logic              setup_c;
    logic              go_ready_c;
    logic              wr_en_c;
    logic              err_c;
    logic [DATA_W-1:0] rdata_c;

    // Decode the live bus in IDLE so a zero-wait transfer can respond right
    // after its setup phase; otherwise decode the captured request.
    always_comb begin
        setup_c     = (state == IDLE) && PSEL && !PENABLE;
        dec_addr_c  = (state == IDLE) ? PADDR  : req.addr;
        dec_write_c = (state == IDLE) ? PWRITE : req.write;
        go_ready_c  = (setup_c && (WAIT_CYC == 0)) ||
                      ((state == WAIT) && PSEL && PENABLE && (cnt == CNT_W'(1)));
        wr_en_c     = (state == READY) && PSEL && req.write;
    end

    apb_slv_regfile #(
        .BASE(BASE)
    ) u_regfile (
        .clk    (PCLK),
        .rst_n  (PRST_n),
        .addr   (dec_addr_c),
        .write  (dec_write_c),
        .wr_en  (wr_en_c),
        .wdata  (req.wdata),
        .rdata_c(rdata_c),
        .err_c  (err_c),
        .ctrl   (CTRL_O)
    );

    always_ff @(posedge PCLK or negedge PRST_n) begin
        if (!PRST_n) begin
            state   <= IDLE;
            cnt     <= '0;
            req     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= RESP_OKAY;
            PRDATA  <= '0;
        end else begin
            PREADY  <= 1'b0;
            PSLVERR <= RESP_OKAY;
            PRDATA  <= '0;
            unique case (state)
                IDLE: begin
                    if (setup_c) begin
                        req   <= '{addr: PADDR, write: PWRITE, wdata: PWDATA};
                        cnt   <= CNT_W'(WAIT_CYC);
                        state <= (WAIT_CYC > 0) ? WAIT : READY;
                    end
                end
                WAIT: begin
                    if (!PSEL) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (PENABLE) begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= READY;
                        end
                    end
                end
                READY:   state <= IDLE;
                default: state <= IDLE;
            endcase
            // Response flops are loaded on entry to READY so they hold for exactly that cycle
            if (go_ready_c) begin
                PREADY  <= 1'b1;
                PSLVERR <= err_c ? RESP_SLVERR : RESP_OKAY;
                PRDATA  <= dec_write_c ? '0 : rdata_c;
            end
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: one instance with two wait states, one with none,
// checked against an array model of the register map.
module tb_apb_reg_slave;

    localparam logic [31:0] ID = 32'hA2B0_0001;

    logic        clk;
    logic        rst_n;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [15:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];
    logic [31:0] ctrl    [2];

    int          total;
    int          bad;
    logic [31:0] model [2][8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    apb_reg_slave #(.WAIT_CYC(2), .BASE(8'h10)) u_w2 (
        .PCLK(clk), .PRST_n(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .CTRL_O(ctrl[0])
    );

    apb_reg_slave #(.WAIT_CYC(0), .BASE(8'h10)) u_w0 (
        .PCLK(clk), .PRST_n(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .CTRL_O(ctrl[1])
    );

    function automatic int exp_waits(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic bit exp_err(input logic [15:0] a, input bit wr);
        int ai;
        ai = int'(a);
        return (ai / 256 != 16) || ((ai % 256) / 32 != 0) || (ai % 4 != 0) ||
               (wr && (ai % 256 == 28));
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 7; i++) model[d][i] = 32'h0;
            model[d][7] = ID;
        end
    endfunction

    // Applies one completed transfer to the model; returns the read data owed
    function automatic logic [31:0] model_xfer(input int d, input bit wr,
                                               input logic [15:0] a, input logic [31:0] wd);
        int idx;
        idx = (int'(a) % 32) / 4;
        if (exp_err(a, wr)) return 32'h0;
        if (wr) begin
            if (idx < 7) model[d][idx] = wd;
            return 32'h0;
        end
        return model[d][idx];
    endfunction

    task automatic bus_idle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0;
            penable[d] = 1'b0;
        end
    endtask

    // One full transfer; returns at the negedge of the PREADY cycle with PSEL still high
    task automatic xfer(input int d, input bit wr, input logic [15:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int waits, output int stray);
        waits = 0;
        stray = 0;
        @(negedge clk);
        if (pready[d] !== 1'b0 || prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) stray++;
        psel[1-d]    = 1'b0;
        penable[1-d] = 1'b0;
        psel[d]      = 1'b1;
        penable[d]   = 1'b0;
        pwrite[d]    = wr;
        paddr[d]     = a;
        pwdata[d]    = wd;
        @(negedge clk);
        penable[d] = 1'b1;
        while (pready[d] !== 1'b1 && waits < 40) begin
            if (prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) stray++;
            waits++;
            @(negedge clk);
        end
        rd = prdata[d];
        er = pslverr[d];
    endtask

    task automatic test_reset();
        logic [31:0] rd, erd;
        logic        er;
        int          w, s;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 32'h0 || ctrl[d] !== 32'h0) begin
                bad++;
                $display("FAIL reset_outputs dut%0d: pready=%b pslverr=%b prdata=%h ctrl=%h, want all zero",
                         d, pready[d], pslverr[d], prdata[d], ctrl[d]);
            end
        end
        rst_n = 1'b1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                erd = model_xfer(d, 1'b0, 16'h1000 + 16'(i * 4), 32'h0);
                xfer(d, 1'b0, 16'h1000 + 16'(i * 4), 32'h0, rd, er, w, s);
                total++;
                if (rd !== erd || er !== 1'b0 || w != exp_waits(d) || s != 0) begin
                    bad++;
                    $display("FAIL reset_read dut%0d reg%0d: rd=%h err=%b waits=%0d stray=%0d, want rd=%h err=0 waits=%0d stray=0",
                             d, i, rd, er, w, s, erd, exp_waits(d));
                end
            end
        end
        bus_idle();
    endtask

    task automatic test_write_read();
        logic [31:0] rd, erd;
        logic        er;
        int          w, s;
        erd = model_xfer(0, 1'b1, 16'h1014, 32'h0000_1248);
        xfer(0, 1'b1, 16'h1014, 32'h0000_1248, rd, er, w, s);
        total++;
        if (w != 2 || er !== 1'b0 || rd !== 32'h0 || s != 0) begin
            bad++;
            $display("FAIL write_1014: waits=%0d err=%b rd=%h stray=%0d, want waits=2 err=0 rd=0 stray=0", w, er, rd, s);
        end
        bus_idle();
        erd = model_xfer(0, 1'b0, 16'h1014, 32'h0);
        xfer(0, 1'b0, 16'h1014, 32'h0, rd, er, w, s);
        total++;
        if (rd !== 32'h0000_1248 || erd !== 32'h0000_1248 || er !== 1'b0 || w != 2 || s != 0) begin
            bad++;
            $display("FAIL read_1014: rd=%h err=%b waits=%0d stray=%0d, want rd=00001248 err=0 waits=2", rd, er, w, s);
        end
        bus_idle();
    endtask

    task automatic test_id();
        logic [31:0] rd, erd;
        logic        er;
        int          w, s;
        xfer(0, 1'b0, 16'h101C, 32'h0, rd, er, w, s);
        total++;
        if (rd !== ID || er !== 1'b0 || s != 0) begin
            bad++;
            $display("FAIL id_read: rd=%h err=%b stray=%0d, want rd=%h err=0", rd, er, s, ID);
        end
        erd = model_xfer(0, 1'b1, 16'h101C, 32'hFFFF_FFFF);
        xfer(0, 1'b1, 16'h101C, 32'hFFFF_FFFF, rd, er, w, s);
        total++;
        if (er !== 1'b1 || rd !== erd || w != 2 || s != 0) begin
            bad++;
            $display("FAIL id_write: err=%b rd=%h waits=%0d stray=%0d, want err=1 rd=0 waits=2", er, rd, w, s);
        end
        xfer(0, 1'b0, 16'h101C, 32'h0, rd, er, w, s);
        total++;
        if (rd !== ID || er !== 1'b0 || s != 0) begin
            bad++;
            $display("FAIL id_reread: rd=%h err=%b stray=%0d, want rd=%h err=0", rd, er, s, ID);
        end
        bus_idle();
    endtask

    task automatic test_errors();
        logic [15:0] ea [3];
        bit          ew [3];
        logic [31:0] ed [3];
        logic [31:0] rd, erd;
        logic        er;
        int          w, s;
        ea = '{16'h2000, 16'h1006, 16'h1020};
        ew = '{1'b0, 1'b0, 1'b1};
        ed = '{32'h0, 32'h0, 32'h0000_1234};
        for (int k = 0; k < 3; k++) begin
            erd = model_xfer(0, ew[k], ea[k], ed[k]);
            xfer(0, ew[k], ea[k], ed[k], rd, er, w, s);
            total++;
            if (er !== 1'b1 || rd !== 32'h0 || erd !== 32'h0 || w != 2 || s != 0) begin
                bad++;
                $display("FAIL error_%h: err=%b rd=%h waits=%0d stray=%0d, want err=1 rd=0 waits=2", ea[k], er, rd, w, s);
            end
        end
        for (int i = 0; i < 7; i++) begin
            erd = model_xfer(0, 1'b0, 16'h1000 + 16'(i * 4), 32'h0);
            xfer(0, 1'b0, 16'h1000 + 16'(i * 4), 32'h0, rd, er, w, s);
            total++;
            if (rd !== erd || er !== 1'b0) begin
                bad++;
                $display("FAIL error_unchanged reg%0d: rd=%h err=%b, want rd=%h err=0", i, rd, er, erd);
            end
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, erd;
        logic        er;
        int          w, s;
        erd = model_xfer(1, 1'b1, 16'h1000, 32'h0000_124C);
        xfer(1, 1'b1, 16'h1000, 32'h0000_124C, rd, er, w, s);
        total++;
        if (w != 0 || er !== 1'b0 || rd !== 32'h0 || s != 0) begin
            bad++;
            $display("FAIL b2b_write: waits=%0d err=%b rd=%h stray=%0d, want waits=0 err=0 rd=0", w, er, rd, s);
        end
        erd = model_xfer(1, 1'b0, 16'h1000, 32'h0);
        xfer(1, 1'b0, 16'h1000, 32'h0, rd, er, w, s);
        total++;
        if (w != 0 || rd !== 32'h0000_124C || er !== 1'b0 || s != 0 || ctrl[1] !== 32'h0000_124C) begin
            bad++;
            $display("FAIL b2b_read: waits=%0d rd=%h err=%b stray=%0d ctrl=%h, want waits=0 rd=0000124C ctrl=0000124C",
                     w, rd, er, s, ctrl[1]);
        end
        erd = model_xfer(0, 1'b1, 16'h100C, 32'hCAFE_0003);
        xfer(0, 1'b1, 16'h100C, 32'hCAFE_0003, rd, er, w, s);
        erd = model_xfer(0, 1'b0, 16'h100C, 32'h0);
        xfer(0, 1'b0, 16'h100C, 32'h0, rd, er, w, s);
        total++;
        if (rd !== erd || w != 2 || s != 0) begin
            bad++;
            $display("FAIL b2b_wait_read: rd=%h waits=%0d stray=%0d, want rd=%h waits=2", rd, w, s, erd);
        end
        bus_idle();
        total++;
        if (pready[0] !== 1'b0 || prdata[0] !== 32'h0 || pslverr[0] !== 1'b0) begin
            bad++;
            $display("FAIL after_ready: pready=%b prdata=%h pslverr=%b, want all zero", pready[0], prdata[0], pslverr[0]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, erd;
        logic        er;
        int          w, s, guard;
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 16'h1004; pwdata[0] = 32'h0000_1284;
        @(negedge clk);
        penable[0] = 1'b1;
        @(negedge clk);
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge clk);
        total++;
        if (pready[0] !== 1'b0) begin
            bad++;
            $display("FAIL abort_wait_pready: pready=%b, want 0", pready[0]);
        end
        repeat (3) @(negedge clk);
        erd = model_xfer(0, 1'b0, 16'h1004, 32'h0);
        xfer(0, 1'b0, 16'h1004, 32'h0, rd, er, w, s);
        total++;
        if (rd !== 32'h0 || erd !== 32'h0 || er !== 1'b0 || w != 2 || s != 0) begin
            bad++;
            $display("FAIL abort_wait_read: rd=%h err=%b waits=%0d stray=%0d, want rd=0 err=0 waits=2", rd, er, w, s);
        end
        bus_idle();
        // Drop PSEL while PREADY is high: the write must not land
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 16'h1018; pwdata[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        penable[0] = 1'b1;
        guard = 0;
        while (pready[0] !== 1'b1 && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge clk);
        total++;
        if (pready[0] !== 1'b0 || guard != 2) begin
            bad++;
            $display("FAIL abort_ready: pready=%b waits=%0d, want pready=0 waits=2", pready[0], guard);
        end
        erd = model_xfer(0, 1'b0, 16'h1018, 32'h0);
        xfer(0, 1'b0, 16'h1018, 32'h0, rd, er, w, s);
        total++;
        if (rd !== erd || er !== 1'b0 || s != 0) begin
            bad++;
            $display("FAIL abort_ready_read: rd=%h err=%b stray=%0d, want rd=%h", rd, er, s, erd);
        end
        bus_idle();
    endtask

    task automatic test_penable_only();
        logic [31:0] rd, erd;
        logic        er;
        int          w, s, hits;
        hits = 0;
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 16'h1000; pwdata[0] = 32'hFFFF_FFFF;
        repeat (5) begin
            @(negedge clk);
            if (pready[0] !== 1'b0) hits++;
        end
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL penable_only: pready seen high %0d cycles, want 0", hits);
        end
        bus_idle();
        erd = model_xfer(0, 1'b0, 16'h1000, 32'h0);
        xfer(0, 1'b0, 16'h1000, 32'h0, rd, er, w, s);
        total++;
        if (rd !== erd || w != 2 || s != 0) begin
            bad++;
            $display("FAIL penable_only_read: rd=%h waits=%0d stray=%0d, want rd=%h waits=2", rd, w, s, erd);
        end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd;
        logic        er;
        int          w, s;
        erd = model_xfer(0, 1'b1, 16'h1000, 32'h0000_0055);
        xfer(0, 1'b1, 16'h1000, 32'h0000_0055, rd, er, w, s);
        bus_idle();
        total++;
        if (ctrl[0] !== 32'h0000_0055) begin
            bad++;
            $display("FAIL ctrl_before_reset: ctrl=%h, want 00000055", ctrl[0]);
        end
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 16'h1008; pwdata[0] = 32'hDEAD_0001;
        @(negedge clk);
        penable[0] = 1'b1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 16'h1010; pwdata[1] = 32'h0000_0077;
        @(negedge clk);
        penable[1] = 1'b1;
        total++;
        if (pready[1] !== 1'b1 || pready[0] !== 1'b0) begin
            bad++;
            $display("FAIL pre_reset_state: pready0=%b pready1=%b, want 0 and 1", pready[0], pready[1]);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (pready[0] !== 1'b0 || pready[1] !== 1'b0 || ctrl[0] !== 32'h0 || ctrl[1] !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: pready0=%b pready1=%b ctrl0=%h ctrl1=%h, want all zero",
                     pready[0], pready[1], ctrl[0], ctrl[1]);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0;
        end
        rst_n = 1'b1;
        model_reset();
        erd = model_xfer(0, 1'b0, 16'h1008, 32'h0);
        xfer(0, 1'b0, 16'h1008, 32'h0, rd, er, w, s);
        total++;
        if (rd !== 32'h0 || erd !== 32'h0 || w != 2 || er !== 1'b0 || s != 0) begin
            bad++;
            $display("FAIL reset_mid_read0: rd=%h waits=%0d err=%b stray=%0d, want rd=0 waits=2 err=0", rd, w, er, s);
        end
        xfer(1, 1'b0, 16'h1010, 32'h0, rd, er, w, s);
        total++;
        if (rd !== 32'h0 || w != 0 || er !== 1'b0 || s != 0) begin
            bad++;
            $display("FAIL reset_mid_read1: rd=%h waits=%0d err=%b stray=%0d, want rd=0 waits=0 err=0", rd, w, er, s);
        end
        bus_idle();
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, wd;
        logic [15:0] a;
        logic        er;
        bit          wr, ee;
        int          w, s, d, r;
        for (int n = 0; n < 300; n++) begin
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            r  = int'($urandom_range(0, 15));
            a  = {8'h10, 3'b000, 3'($urandom_range(0, 7)), 2'b00};
            if (r == 0) a[15:8] = 8'($urandom_range(0, 255));
            if (r == 1) a[7:5]  = 3'($urandom_range(0, 7));
            if (r == 2) a[1:0]  = 2'($urandom_range(0, 3));
            ee  = exp_err(a, wr);
            erd = model_xfer(d, wr, a, wd);
            xfer(d, wr, a, wd, rd, er, w, s);
            total++;
            if (rd !== erd || er !== ee || w != exp_waits(d) || s != 0) begin
                bad++;
                $display("FAIL random#%0d dut%0d %s %h: rd=%h err=%b waits=%0d stray=%0d, want rd=%h err=%b waits=%0d",
                         n, d, wr ? "wr" : "rd", a, rd, er, w, s, erd, ee, exp_waits(d));
            end
            if ($urandom_range(0, 3) == 0) begin
                bus_idle();
                total++;
                if (pready[d] !== 1'b0 || prdata[d] !== 32'h0 || pslverr[d] !== 1'b0 ||
                    ctrl[0] !== model[0][0] || ctrl[1] !== model[1][0]) begin
                    bad++;
                    $display("FAIL random_idle#%0d: pready=%b prdata=%h pslverr=%b ctrl0=%h ctrl1=%h, want 0 0 0 %h %h",
                             n, pready[d], prdata[d], pslverr[d], ctrl[0], ctrl[1], model[0][0], model[1][0]);
                end
            end
        end
        bus_idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 16'h0; pwdata[d] = 32'h0;
        end
        test_reset();
        test_write_read();
        test_id();
        test_errors();
        test_back_to_back();
        test_abort();
        test_penable_only();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
